// File: rtl/teclado_pin.sv
// 4x4 matrix-keypad scanner with column synchronizer, press/release debounce and digit strobe.
// Optional 4-digit limit on emitted strobes when TECLADO_LIMITE_DIGITOS_EN is defined.
module teclado_pin #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CICLOS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tarjeta_recibida,
    input  logic [3:0] columnas,
    output logic [3:0] filas,
    output logic       digito_stb,
    output logic [3:0] digito,
    output logic       tecla_presionada,
    output logic       pin_completo
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CICLOS + 1);

    typedef enum logic [1:0] {
        REPOSO    = 2'd0,
        ESCANEO   = 2'd1,
        VALIDANDO = 2'd2,
        SOLTAR    = 2'd3
    } estado_t;

    estado_t          estado_r;
    logic [3:0]       col_m_r;
    logic [3:0]       col_s_r;
    logic [1:0]       fila_r;
    logic [3:0]       filas_r;
    logic [3:0]       col_lat_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             digito_stb_r;
    logic [3:0]       digito_r;
    logic             tecla_r;
    logic [4:0]       tecla_info_s;
    logic             bloqueo_s;

    function automatic logic una_baja(input logic [3:0] c);
        logic [3:0] b;
        b = ~c;
        return (b != 4'd0) && ((b & (b - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] col_idx(input logic [3:0] c);
        logic [1:0] idx;
        case (c)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {is_digit, value} for a (row, column) keypad position.
    function automatic logic [4:0] tecla_dig(input logic [1:0] f, input logic [1:0] c);
        logic [4:0] r;
        case ({f, c})
            4'b00_00: r = 5'b1_0001;
            4'b00_01: r = 5'b1_0010;
            4'b00_10: r = 5'b1_0011;
            4'b01_00: r = 5'b1_0100;
            4'b01_01: r = 5'b1_0101;
            4'b01_10: r = 5'b1_0110;
            4'b10_00: r = 5'b1_0111;
            4'b10_01: r = 5'b1_1000;
            4'b10_10: r = 5'b1_1001;
            4'b11_01: r = 5'b1_0000;
            default:  r = 5'b0_0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] fila_drive(input logic [1:0] f);
        logic [3:0] one;
        one = 4'b0001 << f;
        return ~one;
    endfunction

    // Decode of the latched key used at the moment the debounce completes.
    always_comb begin
        tecla_info_s = tecla_dig(fila_r, col_idx(col_lat_r));
    end

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_m_r <= 4'b1111;
            col_s_r <= 4'b1111;
        end else begin
            col_m_r <= columnas;
            col_s_r <= col_m_r;
        end
    end

    // Scan / validate / release state machine with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_r     <= REPOSO;
            fila_r       <= 2'd0;
            filas_r      <= 4'b1111;
            col_lat_r    <= 4'b1111;
            div_cnt_r    <= '0;
            deb_cnt_r    <= '0;
            digito_stb_r <= 1'b0;
            digito_r     <= 4'd0;
            tecla_r      <= 1'b0;
        end else if (!tarjeta_recibida) begin
            estado_r     <= REPOSO;
            fila_r       <= 2'd0;
            filas_r      <= 4'b1111;
            div_cnt_r    <= '0;
            deb_cnt_r    <= '0;
            digito_stb_r <= 1'b0;
            tecla_r      <= 1'b0;
        end else begin
            digito_stb_r <= 1'b0;
            case (estado_r)
                REPOSO: begin
                    estado_r  <= ESCANEO;
                    fila_r    <= 2'd0;
                    filas_r   <= fila_drive(2'd0);
                    div_cnt_r <= '0;
                end
                ESCANEO: begin
                    if (div_cnt_r == DIV_W'(SCAN_DIV - 1)) begin
                        div_cnt_r <= '0;
                        if (una_baja(col_s_r)) begin
                            col_lat_r <= col_s_r;
                            deb_cnt_r <= '0;
                            estado_r  <= VALIDANDO;
                        end else begin
                            fila_r  <= fila_r + 2'd1;
                            filas_r <= fila_drive(fila_r + 2'd1);
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_W'(1);
                    end
                end
                VALIDANDO: begin
                    if (col_s_r == col_lat_r) begin
                        if (deb_cnt_r == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
                            tecla_r   <= 1'b1;
                            deb_cnt_r <= '0;
                            estado_r  <= SOLTAR;
                            if (tecla_info_s[4] && !bloqueo_s) begin
                                digito_r     <= tecla_info_s[3:0];
                                digito_stb_r <= 1'b1;
                            end
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                        end
                    end else begin
                        estado_r  <= ESCANEO;
                        div_cnt_r <= '0;
                        fila_r    <= fila_r + 2'd1;
                        filas_r   <= fila_drive(fila_r + 2'd1);
                    end
                end
                SOLTAR: begin
                    if (col_s_r == 4'b1111) begin
                        if (deb_cnt_r == DEB_W'(DEBOUNCE_CICLOS - 1)) begin
                            tecla_r   <= 1'b0;
                            deb_cnt_r <= '0;
                            div_cnt_r <= '0;
                            estado_r  <= ESCANEO;
                            fila_r    <= fila_r + 2'd1;
                            filas_r   <= fila_drive(fila_r + 2'd1);
                        end else begin
                            deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                        end
                    end else begin
                        deb_cnt_r <= '0;
                    end
                end
                default: begin
                    estado_r <= REPOSO;
                    filas_r  <= 4'b1111;
                    tecla_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TECLADO_LIMITE_DIGITOS_EN
    logic [2:0] cnt_dig_r;
    logic       pin_completo_r;

    // Counts emitted strobes; the flag follows the fourth one by a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_dig_r      <= 3'd0;
            pin_completo_r <= 1'b0;
        end else if (!tarjeta_recibida) begin
            cnt_dig_r      <= 3'd0;
            pin_completo_r <= 1'b0;
        end else if (digito_stb_r) begin
            cnt_dig_r <= cnt_dig_r + 3'd1;
            if (cnt_dig_r == 3'd3) begin
                pin_completo_r <= 1'b1;
            end
        end
    end

    assign bloqueo_s    = pin_completo_r;
    assign pin_completo = pin_completo_r;
`else
    assign bloqueo_s    = 1'b0;
    assign pin_completo = 1'b0;
`endif

    assign filas            = filas_r;
    assign digito_stb       = digito_stb_r;
    assign digito           = digito_r;
    assign tecla_presionada = tecla_r;

endmodule

// File: tb/tb_teclado_pin.sv
// Directed bench for teclado_pin: a combinational keypad model reacts to the row drive.
module tb_teclado_pin;

    logic       clk;
    logic       reset;
    logic       tarjeta_recibida;
    logic [3:0] columnas;
    logic [3:0] filas;
    logic       digito_stb;
    logic [3:0] digito;
    logic       tecla_presionada;
    logic       pin_completo;

    logic [3:0][3:0] pulsado;
    int checks;
    int failures;
    int stb_cnt;

    typedef struct {
        logic [1:0] fila;
        logic [3:0] cols;
        int         exp_stb;
        logic [3:0] exp_dig;
        logic       exp_pin;
    } vec_t;

    vec_t vecs [6];

    teclado_pin dut (
        .clk              (clk),
        .reset            (reset),
        .tarjeta_recibida (tarjeta_recibida),
        .columnas         (columnas),
        .filas            (filas),
        .digito_stb       (digito_stb),
        .digito           (digito),
        .tecla_presionada (tecla_presionada),
        .pin_completo     (pin_completo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        logic [3:0] mask;
        mask = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!filas[r]) mask = mask | pulsado[r];
        end
        columnas = ~mask;
    end

    always @(negedge clk) begin
        if (digito_stb === 1'b1) stb_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic esperar_tecla(input logic v, input int maxc, output int n);
        n = 0;
        while (tecla_presionada !== v && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic esperar_filas(input logic [3:0] v, input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (filas !== v && n < maxc);
    endtask

    initial begin
        int n, s0, errs, vista;
        logic [3:0] exp_f;
        logic [3:0] uno;
        checks = 0; failures = 0; stb_cnt = 0;
        pulsado = '0;
        reset = 1'b0;
        tarjeta_recibida = 1'b0;

        vecs[0] = '{2'd0, 4'b1000, 0, 4'd0, 1'b0};
        vecs[1] = '{2'd0, 4'b0001, 1, 4'd1, 1'b0};
        vecs[2] = '{2'd0, 4'b0010, 1, 4'd2, 1'b0};
        vecs[3] = '{2'd0, 4'b0100, 1, 4'd3, 1'b0};
`ifdef TECLADO_LIMITE_DIGITOS_EN
        vecs[4] = '{2'd1, 4'b0001, 1, 4'd4, 1'b1};
        vecs[5] = '{2'd2, 4'b0100, 0, 4'd4, 1'b1};
`else
        vecs[4] = '{2'd1, 4'b0001, 1, 4'd4, 1'b0};
        vecs[5] = '{2'd2, 4'b0100, 1, 4'd9, 1'b0};
`endif

        ciclos(3);
        chk("rst_filas", int'(filas), 15);
        chk("rst_digito", int'(digito), 0);
        chk("rst_stb", int'(digito_stb), 0);
        chk("rst_tecla", int'(tecla_presionada), 0);
        chk("rst_pin", int'(pin_completo), 0);

        // Idle scan: each row low for four cycles in turn.
        reset = 1'b1;
        tarjeta_recibida = 1'b1;
        esperar_filas(4'b1110, 10, n);
        chk("scan_start", int'(filas), 14);
        errs = 0;
        for (int i = 0; i < 16; i++) begin
            uno = 4'b0001 << (i / 4);
            exp_f = ~uno;
            if (filas !== exp_f) errs++;
            @(negedge clk);
        end
        chk("scan_seq_errors", errs, 0);
        chk("scan_no_stb", stb_cnt, 0);

        // Hold '5' for 40 cycles, then release.
        s0 = stb_cnt;
        pulsado[1] = 4'b0010;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (digito_stb) chk("tecla_at_stb", int'(tecla_presionada), 1);
        end
        chk("five_stb_count", stb_cnt - s0, 1);
        chk("five_digito", int'(digito), 5);
        pulsado = '0;
        esperar_tecla(1'b0, 30, n);
        chk("five_release_delay", n, 10);

        // '0' with short bounces, then stable.
        s0 = stb_cnt;
        for (int i = 0; i < 4; i++) begin
            pulsado[3] = 4'b0010;
            ciclos(3);
            pulsado = '0;
            ciclos(3);
        end
        chk("bounce_no_stb", stb_cnt - s0, 0);
        pulsado[3] = 4'b0010;
        esperar_tecla(1'b1, 60, n);
        ciclos(2);
        chk("zero_stb_count", stb_cnt - s0, 1);
        chk("zero_digito", int'(digito), 0);
        pulsado = '0;
        esperar_tecla(1'b0, 30, n);
        chk("zero_released", int'(tecla_presionada), 0);

        // '#' debounces without a strobe.
        s0 = stb_cnt;
        pulsado[3] = 4'b0100;
        esperar_tecla(1'b1, 60, n);
        chk("hash_tecla", int'(tecla_presionada), 1);
        ciclos(5);
        chk("hash_no_stb", stb_cnt - s0, 0);
        pulsado = '0;
        esperar_tecla(1'b0, 30, n);
        chk("hash_released", int'(tecla_presionada), 0);

        // Two columns at once on row 0 are ignored.
        vista = 0;
        pulsado[0] = 4'b0101;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tecla_presionada) vista = 1;
        end
        chk("double_no_tecla", vista, 0);
        chk("double_no_stb", stb_cnt - s0, 0);
        pulsado = '0;

        // Card removed while '7' is being validated.
        s0 = stb_cnt;
        esperar_filas(4'b0111, 40, n);
        pulsado[2] = 4'b0001;
        esperar_filas(4'b1011, 40, n);
        ciclos(6);
        tarjeta_recibida = 1'b0;
        @(negedge clk);
        chk("drop_filas", int'(filas), 15);
        chk("drop_tecla", int'(tecla_presionada), 0);
        chk("drop_stb", int'(digito_stb), 0);
        ciclos(20);
        chk("drop_no_stb", stb_cnt - s0, 0);
        pulsado = '0;
        tarjeta_recibida = 1'b1;

        // Reset while waiting for release of '8'.
        s0 = stb_cnt;
        pulsado[2] = 4'b0010;
        esperar_tecla(1'b1, 60, n);
        ciclos(3);
        chk("eight_stb_count", stb_cnt - s0, 1);
        chk("eight_digito", int'(digito), 8);
        reset = 1'b0;
        #1;
        chk("mid_rst_filas", int'(filas), 15);
        chk("mid_rst_digito", int'(digito), 0);
        chk("mid_rst_tecla", int'(tecla_presionada), 0);
        chk("mid_rst_stb", int'(digito_stb), 0);
        ciclos(3);
        pulsado = '0;
        reset = 1'b1;
        s0 = stb_cnt;
        ciclos(40);
        chk("post_rst_no_stb", stb_cnt - s0, 0);

        // PIN sequence A,1,2,3,4,9 after a fresh card insertion.
        tarjeta_recibida = 1'b0;
        ciclos(2);
        tarjeta_recibida = 1'b1;
        for (int v = 0; v < 6; v++) begin
            s0 = stb_cnt;
            pulsado[vecs[v].fila] = vecs[v].cols;
            esperar_tecla(1'b1, 60, n);
            chk("vec_press", int'(tecla_presionada), 1);
            ciclos(3);
            pulsado = '0;
            esperar_tecla(1'b0, 30, n);
            ciclos(2);
            chk("vec_stb_count", stb_cnt - s0, vecs[v].exp_stb);
            chk("vec_digito", int'(digito), int'(vecs[v].exp_dig));
            chk("vec_pin", int'(pin_completo), int'(vecs[v].exp_pin));
        end
        tarjeta_recibida = 1'b0;
        @(negedge clk);
        chk("pin_cleared", int'(pin_completo), 0);
        ciclos(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/teclado_pin.md
# teclado_pin

Matrix-keypad front end for the cashier's PIN entry path. Scans a 4x4 keypad, synchronizes and debounces the column lines and emits each decimal keypress as a single-cycle `digito_stb` with a 4-bit `digito`. This is the digit producer that drives the PIN-receiving block's `digito_stb`/`digito` inputs. It is enabled by `tarjeta_recibida`.

## Interface
- `SCAN_DIV`, 4: cycles each row is driven; minimum 3.
- `DEBOUNCE_CICLOS`, 8: consecutive stable synchronized samples required for press and for release; minimum 1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tarjeta_recibida`  in  1  enable: card present, PIN entry allowed.
- `columnas`  in  4  keypad columns, active-low (pulled up), asynchronous.
- `filas`  out  4  row drive, one-hot active-low; 4'b1111 when idle.
- `digito_stb`  out  1  one-cycle pulse, new digit valid.
- `digito`  out  4  binary digit 0–9; holds last value between strobes.
- `tecla_presionada`  out  1  high while a debounced key (any key) is held.
- `pin_completo`  out  1  four digits sent (see Configuration); constant 0 otherwise.

## Operation
- Key map (row, col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
- Only 0–9 produce a strobe. A, B, C, D, * and # are debounced and assert `tecla_presionada`, but produce no strobe.
- `columnas` passes through a 2-flop synchronizer. All decisions use the synchronized value `col_s`.
- States:
  - REPOSO: `filas`=1111. Go to ESCANEO (row 0) when `tarjeta_recibida`=1.
  - ESCANEO: drive row r for `SCAN_DIV` cycles. Sample `col_s` on the last cycle of the window.
    - Exactly one bit low: latch (r, col), hold row r, clear the debounce counter, go to VALIDANDO.
    - Otherwise (none low or several low): advance to row r+1 mod 4.
  - VALIDANDO: each cycle `col_s` equals the latched pattern, counter +1. Any mismatch returns to ESCANEO at row r+1.
    - When the counter reaches `DEBOUNCE_CICLOS`: assert `tecla_presionada`. If the key is a digit, load `digito` and pulse `digito_stb` in the same cycle. Go to SOLTAR.
  - SOLTAR: hold row r. Require `col_s`=1111 for `DEBOUNCE_CICLOS` consecutive cycles (any low sample restarts the count). Then deassert `tecla_presionada` and go to ESCANEO at row r+1.
- Holding a key produces exactly one strobe; there is no auto-repeat.
- `tarjeta_recibida`=0 in any state: next cycle go to REPOSO, `filas`=1111, `tecla_presionada`=0, no strobe. A strobe pending in that same cycle is suppressed.
- Reset values: state REPOSO, `filas`=1111, `digito`=0000, `digito_stb`=0, `tecla_presionada`=0, `pin_completo`=0, counters 0, synchronizer 1111.

## Timing
- Row window = `SCAN_DIV` cycles. Full scan = 4·`SCAN_DIV` cycles.
- `SCAN_DIV`≥3 guarantees the sampled `col_s` belongs to the currently driven row.
- Press latency: from the sample cycle that detects the key to `digito_stb` = `DEBOUNCE_CICLOS` cycles. Worst case from the `columnas` edge is 2 + 4·`SCAN_DIV` + `DEBOUNCE_CICLOS`.
- `digito_stb` is high for exactly 1 cycle. `digito` is valid in that cycle and stable until the next strobe.
- `tecla_presionada` rises in the strobe cycle. It falls `DEBOUNCE_CICLOS` cycles after `col_s` goes all-high.
- Reset asserted mid-validation or mid-release: immediate return to reset values. No strobe is emitted for the aborted key.

## Configuration
- `TECLADO_LIMITE_DIGITOS_EN` defined:
  - A 3-bit counter counts emitted strobes. On the 4th strobe, `pin_completo` goes to 1 on the following cycle.
  - While `pin_completo`=1, digit keys are still debounced but produce no strobe.
  - The counter and `pin_completo` clear when `tarjeta_recibida` falls or on reset.
- `TECLADO_LIMITE_DIGITOS_EN` undefined: no counter. `pin_completo` is tied to 0 and strobes are unlimited.

## Test plan
- Reset low, then high with `tarjeta_recibida`=1, no key. Required: `filas` cycles 1110→1101→1011→0111, each for 4 cycles; `digito_stb` stays 0.
- Hold '5' (col1 low while r1 driven) for 40 cycles, then release. Required: exactly one `digito_stb` with `digito`=0101. `tecla_presionada` high from the strobe until 8 cycles after release.
- Press '0' with 3-cycle bounce glitches, then stable. Required: glitches produce no strobe; one strobe with `digito`=0000 after stable debounce.
- Press '#', then col0+col2 simultaneously on r0. Required: '#' gives `tecla_presionada`=1 and no strobe; the two-column press is ignored.
- Drop `tarjeta_recibida` during VALIDANDO of '7', and separately assert reset mid-SOLTAR. Required: no strobe, `filas`=1111, all outputs at reset values.
- With `TECLADO_LIMITE_DIGITOS_EN`, enter 1,2,3,4,9. Required: 4 strobes (0001, 0010, 0011, 0100), then `pin_completo`=1 and no strobe for 9. `pin_completo` clears when `tarjeta_recibida` falls.
